// File: rtl/traffic_phase_controller.sv
// Timed two-road phase sequencer: per-phase dwell timers paced by tick, all-red
// clearance, pedestrian-shortened green and emergency preemption hold.
module traffic_phase_controller #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [CNT_W-1:0] green_len_ns,
    input  logic [CNT_W-1:0] green_len_ew,
    input  logic [CNT_W-1:0] yellow_len,
    input  logic [CNT_W-1:0] allred_len,
    input  logic             ped_req,
    input  logic             emerg,
    output logic [1:0]       ns_light,
    output logic [1:0]       ew_light,
    output logic             ped_walk,
    output logic             emerg_active,
    output logic [2:0]       phase
);

    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] AR_A  = 3'd2;
    localparam logic [2:0] EW_G  = 3'd3;
    localparam logic [2:0] EW_Y  = 3'd4;
    localparam logic [2:0] AR_B  = 3'd5;
    localparam logic [2:0] EMERG = 3'd6;

    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_LD = CNT_W'(MIN_GREEN - 1);

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] timer_r, timer_s;
    logic             ped_pending_r, ped_pending_s;
    logic             ped_walk_r, ped_walk_s;
    logic             expire_s;
    logic             enter_ar_s;
    logic             leave_ar_s;

    // Timer reload value: a phase spans max(len,1) ticks, so load len-1 with 0 clamped.
    function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
        if (len == ZERO) begin
            load_len = ZERO;
        end else begin
            load_len = len - ONE;
        end
    endfunction

    // State, dwell timer and pedestrian registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= AR_B;
            timer_r       <= ZERO;
            ped_pending_r <= 1'b0;
            ped_walk_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            ped_pending_r <= ped_pending_s;
            ped_walk_r    <= ped_walk_s;
        end
    end

    // Next-state, timer reload/decrement and pedestrian latch logic.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        expire_s = tick && (timer_r == ZERO);
        case (state_r)
            NS_G: begin
                // Emergency cut outranks expiry; both land in yellow with the same reload.
                if (emerg || expire_s) begin
                    state_s = NS_Y;
                    timer_s = load_len(yellow_len);
                end else if (ped_pending_r && (timer_r > MIN_LD)) begin
                    timer_s = MIN_LD;
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            NS_Y: begin
                if (expire_s) begin
                    state_s = AR_A;
                    timer_s = load_len(allred_len);
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            AR_A: begin
                if (expire_s && emerg) begin
                    state_s = EMERG;
                    timer_s = ZERO;
                end else if (expire_s) begin
                    state_s = EW_G;
                    timer_s = load_len(green_len_ew);
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            EW_G: begin
                if (emerg || expire_s) begin
                    state_s = EW_Y;
                    timer_s = load_len(yellow_len);
                end else if (ped_pending_r && (timer_r > MIN_LD)) begin
                    timer_s = MIN_LD;
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            EW_Y: begin
                if (expire_s) begin
                    state_s = AR_B;
                    timer_s = load_len(allred_len);
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            AR_B: begin
                if (expire_s && emerg) begin
                    state_s = EMERG;
                    timer_s = ZERO;
                end else if (expire_s) begin
                    state_s = NS_G;
                    timer_s = load_len(green_len_ns);
                end else if (tick) begin
                    timer_s = timer_r - ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            EMERG: begin
                if (!emerg) begin
                    state_s = NS_G;
                    timer_s = load_len(green_len_ns);
                end else begin
                    state_s = EMERG;
                    timer_s = timer_r;
                end
            end
            default: begin
                state_s = AR_B;
                timer_s = ZERO;
            end
        endcase

        enter_ar_s = ((state_s == AR_A) || (state_s == AR_B)) && (state_s != state_r);
        leave_ar_s = ((state_r == AR_A) || (state_r == AR_B)) && (state_s != state_r);
        // Walk is granted for the whole clearance interval; pending survives EMERG.
        if (enter_ar_s) begin
            ped_walk_s    = ped_pending_r | ped_req;
            ped_pending_s = 1'b0;
        end else if (leave_ar_s) begin
            ped_walk_s    = 1'b0;
            ped_pending_s = ped_pending_r | ped_req;
        end else begin
            ped_walk_s    = ped_walk_r;
            ped_pending_s = ped_pending_r | ped_req;
        end
    end

    // Lamp and status decode of the registered state.
    always_comb begin
        ns_light     = 2'b00;
        ew_light     = 2'b00;
        ped_walk     = ped_walk_r;
        emerg_active = (state_r == EMERG);
        phase        = state_r;
        case (state_r)
            NS_G: begin
                ns_light = 2'b10;
                ew_light = 2'b00;
            end
            NS_Y: begin
                ns_light = 2'b01;
                ew_light = 2'b00;
            end
            EW_G: begin
                ns_light = 2'b00;
                ew_light = 2'b10;
            end
            EW_Y: begin
                ns_light = 2'b00;
                ew_light = 2'b01;
            end
            default: begin
                ns_light = 2'b00;
                ew_light = 2'b00;
            end
        endcase
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Timed phase sequencer for a two-road intersection, extending the fixed four-state light cycle. It adds the following:
- per-phase dwell timers paced by an external tick strobe;
- programmable green, yellow and all-red lengths;
- all-red clearance intervals between directions;
- a latched pedestrian request that shortens green;
- an emergency preemption hold.

It drives the NS/EW lamp encodings directly and sits between the tick/prescaler logic and the lamp drivers.

## Interface
Parameters:
- CNT_W, 8, width of the dwell timer and all length inputs.
- MIN_GREEN, 3, green dwell (ticks) that a pending pedestrian request truncates green to. Legal range is 1..2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- tick  in  1  single-cycle timing strobe; one tick = one dwell unit.
- green_len_ns  in  CNT_W  NS green length in ticks.
- green_len_ew  in  CNT_W  EW green length in ticks.
- yellow_len  in  CNT_W  yellow length in ticks.
- allred_len  in  CNT_W  all-red clearance length in ticks.
- ped_req  in  1  pedestrian request pulse; any width, level sampled every cycle.
- emerg  in  1  emergency preemption request, level.
- ns_light  out  2  00=Red, 01=Yellow, 10=Green.
- ew_light  out  2  same encoding as ns_light.
- ped_walk  out  1  walk indication.
- emerg_active  out  1  high in the EMERG state.
- phase  out  3  current state code.

## Operation
- States and phase codes:
  - NS_G=0: ns 10, ew 00.
  - NS_Y=1: ns 01, ew 00.
  - AR_A=2: both 00.
  - EW_G=3: ns 00, ew 10.
  - EW_Y=4: ns 00, ew 01.
  - AR_B=5: both 00.
  - EMERG=6: both 00, emerg_active=1.
  - Code 7 is illegal; it decodes to all red and returns to AR_B on the next clk.
- Normal order: NS_G → NS_Y → AR_A → EW_G → EW_Y → AR_B → NS_G.
- Dwell timer:
  - On entry to a phase, the timer loads len-1 from that phase's length input, sampled in the transition cycle.
  - A length of 0 is treated as 1.
  - On a cycle with tick=1: if timer>0, decrement; if timer==0, the phase expires and the transition occurs at that clk edge.
  - A phase therefore spans exactly max(len,1) ticks.
  - Length inputs changed mid-phase have no effect until the next entry.
- Pedestrian request:
  - ped_req=1 sets ped_pending.
  - In NS_G/EW_G with ped_pending=1 and timer>MIN_GREEN-1, the timer is loaded with MIN_GREEN-1 on that cycle. This truncation overrides a simultaneous tick decrement.
  - On entry to AR_A or AR_B, ped_walk is loaded with (ped_pending | ped_req) and ped_pending is cleared; ped_walk holds for the whole all-red phase.
  - ped_walk is cleared on leaving all-red.
  - A request arriving during all-red remains pending for the next all-red.
- Emergency:
  - emerg=1 in NS_G or EW_G: on the next clk (tick not required), move to the matching yellow with the timer loaded from yellow_len.
  - emerg=1 in yellow: the yellow runs to completion.
  - At expiry of AR_A/AR_B with emerg=1: go to EMERG instead of the next green.
  - EMERG holds while emerg=1, ignoring tick.
  - On the first cycle with emerg=0 in EMERG: the next clk enters NS_G with the timer loaded from green_len_ns.
  - If emerg drops before EMERG is reached, sequencing continues normally.
  - ped_pending is retained through EMERG; ped_walk=0 in EMERG.
- Priority per cycle: reset > emergency green-cut > phase expiry > pedestrian truncation > tick decrement.

## Timing
- Reset (async):
  - state=AR_B and timer=0, so the first tick enters NS_G.
  - ped_pending=0.
  - Outputs: ns_light=00, ew_light=00, ped_walk=0, emerg_active=0, phase=5.
- All outputs are a combinational decode of registered state, and ped_walk is itself a register. Outputs therefore change in the same cycle as the state register.
- Expiry-to-lamp-change latency is one clk edge from the expiring tick cycle.
- Emergency green-cut latency is one clk edge from the first emerg=1 sample.
- No two lamps are ever simultaneously non-red. Both directions are red for ≥1 tick between greens.

## Test plan
1. Reset release with tick every cycle, green 5/5, yellow 2, allred 1: AR_B 1 cycle, NS_G 5, NS_Y 2, AR_A 1, EW_G 5, EW_Y 2, AR_B 1; period 16 cycles, phase codes as specified.
2. Length handling: all lengths=0 gives every phase exactly 1 tick. With tick every 4th cycle and green 3, NS_G lasts 12 cycles and transitions occur only on tick cycles.
3. Pedestrian request: green_len_ns=10, MIN_GREEN=3, ped_req pulse on the first NS_G cycle. NS_G lasts 3 ticks, ped_walk=1 for all of AR_A, ped_pending=0 afterward, and the following EW_G lasts the full 10.
4. Emergency: emerg raised mid-EW_G. The next clk gives EW_Y for 2 ticks, then AR_B for 1, then EMERG held with emerg_active=1 for 20 cycles. When emerg drops, the next clk gives NS_G with a full green_len_ns.
5. Simultaneous events: ped_req in the same cycle as AR_A entry gives ped_walk=1. emerg=1 in the same cycle as NS_G expiry goes to NS_Y, then AR_A, then EMERG.
6. Reset asserted mid-EW_Y (timer=1): outputs go to all red with phase=5 immediately without waiting for clk. After release, the first tick enters NS_G.
